// File: rtl/lsu_mem_bridge_if.sv
// Core-side load/store request and data-memory port signals of the LSU bridge.
// The bridge takes the slave modport; the core/memory environment takes the master.
interface lsu_mem_bridge_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              lsu_req;
    logic              lsu_we;
    logic [2:0]        lsu_funct3;
    logic [31:0]       lsu_addr;
    logic [31:0]       lsu_wdata;
    logic [31:0]       lsu_rdata;
    logic              lsu_done;
    logic              lsu_err;
    logic              lsu_busy;
    logic              mem_request;
    logic              mem_w_en;
    logic [ADDR_W-1:0] mem_address;
    logic [31:0]       mem_write_data;
    logic [3:0]        mem_masking;
    logic [31:0]       mem_read_data;
    logic              mem_valid;

    modport slave (
        input  lsu_req, lsu_we, lsu_funct3, lsu_addr, lsu_wdata,
        input  mem_read_data, mem_valid,
        output lsu_rdata, lsu_done, lsu_err, lsu_busy,
        output mem_request, mem_w_en, mem_address, mem_write_data, mem_masking
    );

    modport master (
        output lsu_req, lsu_we, lsu_funct3, lsu_addr, lsu_wdata,
        output mem_read_data, mem_valid,
        input  lsu_rdata, lsu_done, lsu_err, lsu_busy,
        input  mem_request, mem_w_en, mem_address, mem_write_data, mem_masking
    );
endinterface

// File: rtl/lsu_mem_bridge.sv
// RV32I load/store unit: validates one access, drives the ram_top request/valid
// handshake and returns extended load data with a one-cycle done pulse.
module lsu_mem_bridge #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    lsu_mem_bridge_if.slave       bus
);
    localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        off_q, off_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        mask_q, mask_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;

    logic              legal_c;
    logic              aligned_c;
    logic              unused_addr_hi;

    assign unused_addr_hi = ^bus.lsu_addr[31:ADDR_W+2];

    // Byte/half/word selection and extension of the returned memory word.
    function automatic logic [31:0] load_extend(input logic [2:0]  f3,
                                                input logic [1:0]  off,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (f3[1:0])
            2'b00:   r = f3[2] ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   r = f3[2] ? {16'd0, h} : {{16{h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // funct3 legality and natural alignment of the incoming request.
    always_comb begin
        if (bus.lsu_we) begin
            legal_c = !bus.lsu_funct3[2] && (bus.lsu_funct3[1:0] != 2'b11);
        end else begin
            legal_c = (bus.lsu_funct3[1:0] != 2'b11) && !(bus.lsu_funct3[2] && bus.lsu_funct3[1]);
        end
        case (bus.lsu_funct3[1:0])
            2'b01:   aligned_c = !bus.lsu_addr[0];
            2'b10:   aligned_c = (bus.lsu_addr[1:0] == 2'b00);
            default: aligned_c = 1'b1;
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        f3_d    = f3_q;
        off_d   = off_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        mask_d  = mask_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        busy_d  = busy_q;

        case (state_q)
            IDLE: begin
                rdata_d = 32'd0;
                if (bus.lsu_req) begin
                    f3_d   = bus.lsu_funct3;
                    off_d  = bus.lsu_addr[1:0];
                    cnt_d  = '0;
                    busy_d = 1'b1;
                    if (legal_c && aligned_c) begin
                        state_d = ACCESS;
                        req_d   = 1'b1;
                        we_d    = bus.lsu_we;
                        addr_d  = bus.lsu_addr[ADDR_W+1:2];
                        if (bus.lsu_we) begin
                            case (bus.lsu_funct3[1:0])
                                2'b00: begin
                                    mask_d  = 4'b0001 << bus.lsu_addr[1:0];
                                    wdata_d = {4{bus.lsu_wdata[7:0]}};
                                end
                                2'b01: begin
                                    mask_d  = bus.lsu_addr[1] ? 4'b1100 : 4'b0011;
                                    wdata_d = {2{bus.lsu_wdata[15:0]}};
                                end
                                default: begin
                                    mask_d  = 4'b1111;
                                    wdata_d = bus.lsu_wdata;
                                end
                            endcase
                        end else begin
                            mask_d  = 4'b0000;
                            wdata_d = 32'd0;
                        end
                    end else begin
                        state_d = RESP;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end
                end
            end
            ACCESS: begin
                if (bus.mem_valid || (cnt_q == CNT_W'(TIMEOUT_CYC - 1))) begin
                    state_d = RESP;
                    done_d  = 1'b1;
                    err_d   = !bus.mem_valid;
                    rdata_d = (bus.mem_valid && !we_q) ? load_extend(f3_q, off_q, bus.mem_read_data)
                                                       : 32'd0;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    addr_d  = '0;
                    mask_d  = 4'b0000;
                    wdata_d = 32'd0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                rdata_d = 32'd0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            f3_q    <= 3'd0;
            off_q   <= 2'd0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            mask_q  <= 4'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            mask_q  <= mask_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.lsu_rdata      = rdata_q;
    assign bus.lsu_done       = done_q;
    assign bus.lsu_err        = err_q;
    assign bus.lsu_busy       = busy_q;
    assign bus.mem_request    = req_q;
    assign bus.mem_w_en       = we_q;
    assign bus.mem_address    = addr_q;
    assign bus.mem_write_data = wdata_q;
    assign bus.mem_masking    = mask_q;
endmodule

// File: tb/tb_lsu_mem_bridge.sv
// Directed bench for lsu_mem_bridge: stores, extended loads, illegal/misaligned
// requests, memory timeout and reset during an access.
module tb_lsu_mem_bridge;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    lsu_mem_bridge_if #(.ADDR_W(8)) bus ();

    lsu_mem_bridge #(.ADDR_W(8), .TIMEOUT_CYC(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, ".mem_request"}, 32'(bus.mem_request), 32'd0);
        check_eq({tag, ".mem_w_en"}, 32'(bus.mem_w_en), 32'd0);
        check_eq({tag, ".mem_address"}, 32'(bus.mem_address), 32'd0);
        check_eq({tag, ".mem_masking"}, 32'(bus.mem_masking), 32'd0);
        check_eq({tag, ".mem_write_data"}, bus.mem_write_data, 32'd0);
        check_eq({tag, ".lsu_done"}, 32'(bus.lsu_done), 32'd0);
        check_eq({tag, ".lsu_err"}, 32'(bus.lsu_err), 32'd0);
        check_eq({tag, ".lsu_busy"}, 32'(bus.lsu_busy), 32'd0);
        check_eq({tag, ".lsu_rdata"}, bus.lsu_rdata, 32'd0);
    endtask

    // Present one request for a single cycle; returns at the negedge after acceptance.
    task automatic start(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd);
        @(negedge clk);
        bus.lsu_req    = 1'b1;
        bus.lsu_we     = we;
        bus.lsu_funct3 = f3;
        bus.lsu_addr   = addr;
        bus.lsu_wdata  = wd;
        @(negedge clk);
        bus.lsu_req    = 1'b0;
    endtask

    // Full legal access: check memory-side drive, answer after `delay` cycles, check response.
    task automatic run_ok(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] exp_addr, input logic [31:0] exp_mask,
                          input logic [31:0] exp_wdata, input int delay,
                          input logic [31:0] rd, input logic [31:0] exp_rdata);
        start(we, f3, addr, wd);
        check_eq({tag, ".mem_request"}, 32'(bus.mem_request), 32'd1);
        check_eq({tag, ".mem_w_en"}, 32'(bus.mem_w_en), 32'(we));
        check_eq({tag, ".mem_address"}, 32'(bus.mem_address), exp_addr);
        check_eq({tag, ".mem_masking"}, 32'(bus.mem_masking), exp_mask);
        check_eq({tag, ".mem_write_data"}, bus.mem_write_data, exp_wdata);
        check_eq({tag, ".busy"}, 32'(bus.lsu_busy), 32'd1);
        check_eq({tag, ".early_done"}, 32'(bus.lsu_done), 32'd0);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            check_eq({tag, ".req_held"}, 32'(bus.mem_request), 32'd1);
        end
        bus.mem_valid     = 1'b1;
        bus.mem_read_data = rd;
        @(negedge clk);
        bus.mem_valid     = 1'b0;
        check_eq({tag, ".done"}, 32'(bus.lsu_done), 32'd1);
        check_eq({tag, ".err"}, 32'(bus.lsu_err), 32'd0);
        check_eq({tag, ".rdata"}, bus.lsu_rdata, exp_rdata);
        check_eq({tag, ".req_drop"}, 32'(bus.mem_request), 32'd0);
        @(negedge clk);
        check_eq({tag, ".done_pulse"}, 32'(bus.lsu_done), 32'd0);
        check_eq({tag, ".busy_clear"}, 32'(bus.lsu_busy), 32'd0);
    endtask

    // Rejected request: done+err in the next cycle, memory never requested.
    task automatic run_bad(input string tag, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr);
        start(we, f3, addr, 32'hFFFF_FFFF);
        check_eq({tag, ".done"}, 32'(bus.lsu_done), 32'd1);
        check_eq({tag, ".err"}, 32'(bus.lsu_err), 32'd1);
        check_eq({tag, ".mem_request"}, 32'(bus.mem_request), 32'd0);
        check_eq({tag, ".rdata"}, bus.lsu_rdata, 32'd0);
        @(negedge clk);
        check_eq({tag, ".done_pulse"}, 32'(bus.lsu_done), 32'd0);
        check_eq({tag, ".mem_request2"}, 32'(bus.mem_request), 32'd0);
        check_eq({tag, ".busy_clear"}, 32'(bus.lsu_busy), 32'd0);
    endtask

    initial begin
        int req_cycles;
        rst               = 1'b1;
        bus.lsu_req       = 1'b0;
        bus.lsu_we        = 1'b0;
        bus.lsu_funct3    = 3'd0;
        bus.lsu_addr      = 32'd0;
        bus.lsu_wdata     = 32'd0;
        bus.mem_read_data = 32'd0;
        bus.mem_valid     = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // T1: word store then word load
        run_ok("T1.sw", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h04, 32'hF, 32'hDEADBEEF,
               1, 32'h0, 32'h0);
        run_ok("T1.lw", 1'b0, 3'b010, 32'h10, 32'h0, 32'h04, 32'h0, 32'h0,
               2, 32'hDEADBEEF, 32'hDEADBEEF);
        // T2: byte store to lane 3; halfword store to upper half
        run_ok("T2.sb", 1'b1, 3'b000, 32'h13, 32'h000000A5, 32'h04, 32'h8, 32'hA5A5A5A5,
               0, 32'h0, 32'h0);
        run_ok("T2.sh", 1'b1, 3'b001, 32'h0000_0102, 32'h1234_BEEF, 32'h40, 32'hC, 32'hBEEFBEEF,
               0, 32'h0, 32'h0);
        // T3: sign/zero extension, plus upper address bits wrapping
        run_ok("T3.lh", 1'b0, 3'b001, 32'h20, 32'h0, 32'h08, 32'h0, 32'h0,
               0, 32'h00008000, 32'hFFFF8000);
        run_ok("T3.lhu", 1'b0, 3'b101, 32'h20, 32'h0, 32'h08, 32'h0, 32'h0,
               1, 32'h00008000, 32'h00008000);
        run_ok("T3.lb", 1'b0, 3'b000, 32'h21, 32'h0, 32'h08, 32'h0, 32'h0,
               0, 32'h00008000, 32'hFFFFFF80);
        run_ok("T3.lbu", 1'b0, 3'b100, 32'hFFFF_F423, 32'h0, 32'h08, 32'h0, 32'h0,
               0, 32'h9A00_0000, 32'h0000009A);
        run_ok("T3.lh_hi", 1'b0, 3'b001, 32'h22, 32'h0, 32'h08, 32'h0, 32'h0,
               0, 32'h7FFF_8000, 32'h00007FFF);

        // T4: misaligned and illegal requests
        run_bad("T4.lw_mis", 1'b0, 3'b010, 32'h06);
        run_bad("T4.f3_011", 1'b0, 3'b011, 32'h10);
        run_bad("T4.sh_mis", 1'b1, 3'b001, 32'h21);
        run_bad("T4.st_f3_100", 1'b1, 3'b100, 32'h20);

        // T5: memory never answers
        start(1'b0, 3'b010, 32'h44, 32'h0);
        req_cycles = 0;
        while (bus.mem_request && req_cycles < 200) begin
            req_cycles++;
            @(negedge clk);
        end
        check_eq("T5.req_cycles", 32'(req_cycles), 32'd64);
        check_eq("T5.done", 32'(bus.lsu_done), 32'd1);
        check_eq("T5.err", 32'(bus.lsu_err), 32'd1);
        check_eq("T5.rdata", bus.lsu_rdata, 32'd0);
        @(negedge clk);
        check_eq("T5.done_pulse", 32'(bus.lsu_done), 32'd0);
        check_eq("T5.busy_clear", 32'(bus.lsu_busy), 32'd0);

        // T6: reset in the middle of an access, late mem_valid ignored
        start(1'b1, 3'b010, 32'h30, 32'h5555_AAAA);
        check_eq("T6.req_before", 32'(bus.mem_request), 32'd1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_all_zero("T6.async");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_eq("T6.no_done", 32'(bus.lsu_done), 32'd0);
        end
        bus.mem_valid     = 1'b1;
        bus.mem_read_data = 32'hFFFF_FFFF;
        @(negedge clk);
        bus.mem_valid     = 1'b0;
        check_eq("T6.stray_valid_done", 32'(bus.lsu_done), 32'd0);
        check_eq("T6.stray_valid_busy", 32'(bus.lsu_busy), 32'd0);
        run_ok("T6.lw", 1'b0, 3'b010, 32'h30, 32'h0, 32'h0C, 32'h0, 32'h0,
               3, 32'h12345678, 32'h12345678);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
